xy_capture_ctrl: RTL
====================

XY_CAPTURE_CTRL -- requirements
Module: xy_capture_ctrl

Interface
REQ-001 SHALL have parameter DATA_IN_BITS, default 12: signed sample width per channel.
REQ-002 SHALL have parameter ADDRESS_BITS, default 12: sample-buffer address width per bank.
REQ-003 SHALL have parameter SAMPLES_PER_FRAME, default 1024: samples captured per frame, at most 2^ADDRESS_BITS.
REQ-004 SHALL have parameter AUTO_TRIGGER_SAMPLES, default 4096: number of valid samples without a trigger before capture is forced.
REQ-005 SHALL have ports: clock (in, 1): sole clock, rising edge; resetN (in, 1): synchronous, active-low reset.
REQ-006 SHALL have input ports:
- enable (1): capture enable.
- sampleValid (1): one sample pair present this cycle.
- sample1, sample2 (signed DATA_IN_BITS): X and Y channels.
- triggerLevel (signed DATA_IN_BITS): channel-1 threshold.
- drawStarting (1): one-cycle pulse at end of the visible frame, from the curve renderer.
REQ-007 SHALL have output ports:
- writeEnable (1): buffer write strobe.
- writeAddress (ADDRESS_BITS): buffer write address.
- writeData1, writeData2 (DATA_IN_BITS): registered sample1 and sample2.
- writeBank (1): bank being written.
- displayBank (1): bank read by the renderer; always ~writeBank.
- frameReady (1): high in FULL.
- capturing (1): high in CAPTURE.
- frameCount (16): completed bank swaps, wraps 0xFFFF->0.

Function
REQ-008 SHALL implement the states IDLE, WAIT_TRIG, CAPTURE and FULL.
REQ-009 IDLE: enable=1 SHALL go to WAIT_TRIG; enable=0 SHALL stay in IDLE.
REQ-010 WAIT_TRIG SHALL go to CAPTURE on a sampleValid where the previous valid sample1 < triggerLevel and the current sample1 >= triggerLevel (signed compare).
REQ-011 The triggering sample SHALL be written at address 0.
REQ-012 WAIT_TRIG SHALL count valid samples; on reaching AUTO_TRIGGER_SAMPLES it SHALL force CAPTURE, and the sample in that cycle SHALL be written at address 0.
REQ-013 CAPTURE SHALL write every valid sample at sequential addresses; after the write at address SAMPLES_PER_FRAME-1 it SHALL go to FULL with no further writes.
REQ-014 FULL SHALL ignore sampleValid; on drawStarting=1 it SHALL toggle writeBank, increment frameCount, and then go to WAIT_TRIG if enable=1, else IDLE.
REQ-015 A drawStarting pulse outside FULL SHALL be ignored, with no bank swap; the renderer redisplays the old bank.
REQ-016 If the last CAPTURE write and drawStarting occur in the same cycle, the swap SHALL NOT happen until the next drawStarting.
REQ-017 If enable falls in WAIT_TRIG or CAPTURE, the block SHALL go to IDLE next cycle, clear the address and auto-trigger counters, and leave the bank unchanged; FULL SHALL complete its pending swap regardless of enable.
REQ-018 Write latency SHALL be 1 cycle: writeEnable, writeAddress and writeData are registered from the sampleValid cycle.
REQ-019 writeEnable SHALL be 0 in IDLE and FULL, and SHALL never assert for more than one cycle per sampleValid.
REQ-020 The trigger history (previous sample1) SHALL update on every sampleValid, in every state.

Reset
REQ-021 While resetN=0 at a rising clock edge, the block SHALL set: state IDLE, writeEnable 0, writeAddress 0, writeData1/2 0, writeBank 0 (so displayBank 1), frameReady 0, capturing 0, frameCount 0, counters 0, trigger history 0.
REQ-022 Reset SHALL take priority over every other input, including mid-CAPTURE and FULL.

Configuration
REQ-023 Macro XY_CAPTURE_TRIGGER_EN defined: REQ-010 and REQ-012 SHALL apply.
REQ-024 Macro XY_CAPTURE_TRIGGER_EN absent: IDLE and FULL SHALL go directly to CAPTURE, WAIT_TRIG SHALL be unreachable, triggerLevel SHALL be ignored, and no trigger/auto-trigger logic SHALL be present.

Structure
REQ-025 Package xy_scope_pkg SHALL hold the state encoding and the default width constants (DATA_IN_BITS, ADDRESS_BITS, SAMPLES_PER_FRAME).
REQ-026 Sub-module xy_trigger_detect SHALL hold the history register, the signed crossing compare and the auto-trigger counter; it SHALL be instantiated only under XY_CAPTURE_TRIGGER_EN.

Verification
REQ-027 Reset: resetN=0 for 2 cycles during CAPTURE -> all outputs at REQ-021 values; displayBank=1.
REQ-028 Trigger: triggerLevel=0, sample1 ramp -5..+5 on valid -> first write at addr 0 with data 0; capturing=1.
REQ-029 Full frame: 1024 valid samples -> writes at addr 0..1023, frameReady=1; extra samples -> no write; then drawStarting -> writeBank=1, frameCount=1.
REQ-030 Coincidence: drawStarting in the cycle of write 1023 -> no swap; the next drawStarting swaps.
REQ-031 Auto-trigger: constant sample1=100 with triggerLevel=200 -> capture starts at valid sample 4096.
REQ-032 Abort: enable=0 at address 500 -> IDLE; re-enable -> restart at addr 0, same writeBank.

Source files
------------

// File: rtl/xy_scope_pkg.sv
// Shared state encoding and default widths for the XY scope capture path.
package xy_scope_pkg;

    localparam int DATA_IN_BITS      = 12;
    localparam int ADDRESS_BITS      = 12;
    localparam int SAMPLES_PER_FRAME = 1024;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_FULL      = 2'd3
    } captureState_t;

endpackage

// File: rtl/xy_trigger_detect.sv
// Rising-edge level trigger on channel 1 plus an auto-trigger timeout counter.
module xy_trigger_detect #(
    parameter int DATA_IN_BITS         = xy_scope_pkg::DATA_IN_BITS,
    parameter int AUTO_TRIGGER_SAMPLES = 4096
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic                           armed,
    input  logic                           sampleValid,
    input  logic signed [DATA_IN_BITS-1:0] sample1,
    input  logic signed [DATA_IN_BITS-1:0] triggerLevel,
    output logic                           fire
);

    localparam int COUNT_BITS = $clog2(AUTO_TRIGGER_SAMPLES) + 1;
    localparam logic [COUNT_BITS-1:0] AUTO_LAST = COUNT_BITS'(AUTO_TRIGGER_SAMPLES - 1);

    logic signed [DATA_IN_BITS-1:0] prevSample1_r;
    logic [COUNT_BITS-1:0]          autoCount_r;
    logic                           crossing_s;

    // History tracks every valid sample; timeout only runs while armed.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            prevSample1_r <= '0;
            autoCount_r   <= '0;
        end else begin
            if (sampleValid) begin
                prevSample1_r <= sample1;
            end
            if (!armed) begin
                autoCount_r <= '0;
            end else if (sampleValid) begin
                autoCount_r <= autoCount_r + COUNT_BITS'(1);
            end
        end
    end

    // Fire on an upward crossing or on the valid sample that reaches the timeout.
    always_comb begin
        crossing_s = 1'b0;
        fire       = 1'b0;
        if ((prevSample1_r < triggerLevel) && (sample1 >= triggerLevel)) begin
            crossing_s = 1'b1;
        end else begin
            crossing_s = 1'b0;
        end
        if (sampleValid && armed) begin
            fire = crossing_s || (autoCount_r == AUTO_LAST);
        end else begin
            fire = 1'b0;
        end
    end

endmodule

// File: rtl/xy_capture_ctrl.sv
// Double-buffered XY sample capture controller; the trigger path is built only
// when XY_CAPTURE_TRIGGER_EN is defined, otherwise capture starts immediately.
module xy_capture_ctrl
    import xy_scope_pkg::*;
#(
    parameter int DATA_IN_BITS         = xy_scope_pkg::DATA_IN_BITS,
    parameter int ADDRESS_BITS         = xy_scope_pkg::ADDRESS_BITS,
    parameter int SAMPLES_PER_FRAME    = xy_scope_pkg::SAMPLES_PER_FRAME,
    parameter int AUTO_TRIGGER_SAMPLES = 4096
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic                           enable,
    input  logic                           sampleValid,
    input  logic signed [DATA_IN_BITS-1:0] sample1,
    input  logic signed [DATA_IN_BITS-1:0] sample2,
    input  logic signed [DATA_IN_BITS-1:0] triggerLevel,
    input  logic                           drawStarting,
    output logic                           writeEnable,
    output logic [ADDRESS_BITS-1:0]        writeAddress,
    output logic [DATA_IN_BITS-1:0]        writeData1,
    output logic [DATA_IN_BITS-1:0]        writeData2,
    output logic                           writeBank,
    output logic                           displayBank,
    output logic                           frameReady,
    output logic                           capturing,
    output logic [15:0]                    frameCount
);

    localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(SAMPLES_PER_FRAME - 1);

    captureState_t           state_r;
    captureState_t           nextState_s;
    captureState_t           startState_s;
    logic [ADDRESS_BITS-1:0] addrCount_r;
    logic [ADDRESS_BITS-1:0] nextAddr_s;
    logic                    doWrite_s;
    logic                    swap_s;
    logic                    fire_s;

`ifdef XY_CAPTURE_TRIGGER_EN
    assign startState_s = ST_WAIT_TRIG;

    xy_trigger_detect #(
        .DATA_IN_BITS        (DATA_IN_BITS),
        .AUTO_TRIGGER_SAMPLES(AUTO_TRIGGER_SAMPLES)
    ) trigger (
        .clock       (clock),
        .resetN      (resetN),
        .armed       ((state_r == ST_WAIT_TRIG) && enable),
        .sampleValid (sampleValid),
        .sample1     (sample1),
        .triggerLevel(triggerLevel),
        .fire        (fire_s)
    );
`else
    localparam int unusedAutoTrigger = AUTO_TRIGGER_SAMPLES;
    logic unusedTriggerLevel_s;
    assign unusedTriggerLevel_s = ^triggerLevel;
    assign startState_s = ST_CAPTURE;
    assign fire_s       = 1'b0;
`endif

    // Next-state, write strobe and bank-swap decode.
    always_comb begin
        nextState_s = state_r;
        nextAddr_s  = addrCount_r;
        doWrite_s   = 1'b0;
        swap_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                nextAddr_s = '0;
                if (enable) begin
                    nextState_s = startState_s;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_WAIT_TRIG: begin
                nextAddr_s = '0;
`ifdef XY_CAPTURE_TRIGGER_EN
                if (!enable) begin
                    nextState_s = ST_IDLE;
                end else if (fire_s) begin
                    doWrite_s = 1'b1;
                    if (LAST_ADDR == '0) begin
                        nextState_s = ST_FULL;
                    end else begin
                        nextState_s = ST_CAPTURE;
                        nextAddr_s  = ADDRESS_BITS'(1);
                    end
                end else begin
                    nextState_s = ST_WAIT_TRIG;
                end
`else
                nextState_s = ST_IDLE;
`endif
            end
            ST_CAPTURE: begin
                if (!enable) begin
                    nextState_s = ST_IDLE;
                    nextAddr_s  = '0;
                end else if (sampleValid) begin
                    doWrite_s = 1'b1;
                    if (addrCount_r == LAST_ADDR) begin
                        nextState_s = ST_FULL;
                        nextAddr_s  = '0;
                    end else begin
                        nextState_s = ST_CAPTURE;
                        nextAddr_s  = addrCount_r + ADDRESS_BITS'(1);
                    end
                end else begin
                    nextState_s = ST_CAPTURE;
                end
            end
            ST_FULL: begin
                // The pending swap completes even if enable has dropped.
                nextAddr_s = '0;
                if (drawStarting) begin
                    swap_s = 1'b1;
                    if (enable) begin
                        nextState_s = startState_s;
                    end else begin
                        nextState_s = ST_IDLE;
                    end
                end else begin
                    nextState_s = ST_FULL;
                end
            end
            default: begin
                nextState_s = ST_IDLE;
                nextAddr_s  = '0;
            end
        endcase
    end

    // State, write port, bank and status registers.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_r      <= ST_IDLE;
            addrCount_r  <= '0;
            writeEnable  <= 1'b0;
            writeAddress <= '0;
            writeData1   <= '0;
            writeData2   <= '0;
            writeBank    <= 1'b0;
            displayBank  <= 1'b1;
            frameReady   <= 1'b0;
            capturing    <= 1'b0;
            frameCount   <= 16'd0;
        end else begin
            state_r     <= nextState_s;
            addrCount_r <= nextAddr_s;
            writeEnable <= doWrite_s;
            if (doWrite_s) begin
                writeAddress <= addrCount_r;
                writeData1   <= sample1;
                writeData2   <= sample2;
            end
            if (swap_s) begin
                writeBank   <= ~writeBank;
                displayBank <= writeBank;
                frameCount  <= frameCount + 16'd1;
            end
            frameReady <= (nextState_s == ST_FULL);
            capturing  <= (nextState_s == ST_CAPTURE);
        end
    end

endmodule
